uart_tx_sb_ctrl: RTL and testbench

System-bus responder peripheral that serialises bytes written by the core onto the UART tx_o line. It occupies one 16 MB slot of the one-hot peripheral decode, alongside data memory, PS/2 and VGA. It is driven by the same req/we/addr/wd signals as the other peripherals, and its read_data_o is returned through the peripheral read mux. It is the transmit counterpart of the keyboard/RX receive path: one byte per frame, with no FIFO.

---
 rtl/uart_tx_sb_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_sb_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sb_ctrl.sv
// System-bus UART transmitter: one byte per frame, optional even parity, 1 or 2 stop bits.
// Registered reads; configuration is frozen while a frame is in flight.
`timescale 1ns/1ps
module uart_tx_sb_ctrl #(
   parameter int unsigned DEFAULT_DIV = 87,
   parameter int unsigned MIN_DIV     = 16
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        tx_o,
   output logic        busy_o
);

   localparam logic [15:0] C_DEF_DIV = 16'(DEFAULT_DIV);
   localparam logic [15:0] C_MIN_DIV = 16'(MIN_DIV);

   localparam logic [23:0] A_DATA   = 24'h000000;
   localparam logic [23:0] A_BUSY   = 24'h000004;
   localparam logic [23:0] A_DIV    = 24'h000008;
   localparam logic [23:0] A_PARITY = 24'h00000C;
   localparam logic [23:0] A_STOP2  = 24'h000010;
   localparam logic [23:0] A_SRST   = 24'h000024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [2:0]  r_idx;
   logic [2:0]  w_idx_nxt;
   logic        r_stop_cnt;
   logic        w_stop_cnt_nxt;

   logic [7:0]  r_byte;
   logic [15:0] r_div;
   logic        r_par_en;
   logic        r_stop2;
   logic [31:0] r_rd_data;

   logic [23:0] w_off;
   logic        w_wr;
   logic        w_rd;
   logic        w_idle;
   logic        w_data_wr;
   logic        w_cfg_wr;
   logic        w_srst;
   logic        w_bit_end;
   logic [15:0] w_div_wdata;
   logic [31:0] w_rd_mux;
   logic        w_tx;
   logic        w_unused;

   assign w_off       = addr_i[23:0];
   assign w_wr        = req_i & write_enable_i;
   assign w_rd        = req_i & ~write_enable_i;
   assign w_idle      = (r_state == S_IDLE);
   assign w_data_wr   = w_wr && (w_off == A_DATA) && w_idle;
   assign w_cfg_wr    = w_wr && w_idle;
   assign w_srst      = w_wr && (w_off == A_SRST) && write_data_i[0];
   assign w_bit_end   = (r_cnt == 16'd0);
   assign w_div_wdata = (write_data_i[15:0] < C_MIN_DIV) ? C_MIN_DIV : write_data_i[15:0];
   assign w_unused    = ^{addr_i[31:24], write_data_i[31:16]};

   assign busy_o      = ~w_idle;
   assign tx_o        = w_tx;
   assign read_data_o = r_rd_data;

   always_comb begin
      w_rd_mux = 32'd0;
      case (w_off)
         A_DATA:   w_rd_mux = {24'd0, r_byte};
         A_BUSY:   w_rd_mux = {31'd0, busy_o};
         A_DIV:    w_rd_mux = {16'd0, r_div};
         A_PARITY: w_rd_mux = {31'd0, r_par_en};
         A_STOP2:  w_rd_mux = {31'd0, r_stop2};
         default:  w_rd_mux = 32'd0;
      endcase
   end

   // Soft reset acts like the hardware reset, one edge later than the write request.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_byte    <= 8'd0;
         r_div     <= C_DEF_DIV;
         r_par_en  <= 1'b0;
         r_stop2   <= 1'b0;
         r_rd_data <= 32'd0;
      end else if (w_srst) begin
         r_byte    <= 8'd0;
         r_div     <= C_DEF_DIV;
         r_par_en  <= 1'b0;
         r_stop2   <= 1'b0;
         r_rd_data <= 32'd0;
      end else begin
         if (w_data_wr) r_byte <= write_data_i[7:0];
         if (w_cfg_wr && (w_off == A_DIV)) r_div <= w_div_wdata;
         if (w_cfg_wr && (w_off == A_PARITY)) r_par_en <= write_data_i[0];
         if (w_cfg_wr && (w_off == A_STOP2)) r_stop2 <= write_data_i[0];
         if (w_rd) r_rd_data <= w_rd_mux;
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= 16'd0;
         r_idx      <= 3'd0;
         r_stop_cnt <= 1'b0;
      end else if (w_srst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 16'd0;
         r_idx      <= 3'd0;
         r_stop_cnt <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
      end
   end

   // Bit timer counts div-1 down to 0; every state change reloads it.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt - 16'd1;
      w_idx_nxt      = r_idx;
      w_stop_cnt_nxt = r_stop_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 16'd0;
            if (w_data_wr) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = r_div - 16'd1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_cnt_nxt   = r_div - 16'd1;
               w_idx_nxt   = 3'd0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = r_div - 16'd1;
               if (r_idx == 3'd7) begin
                  w_state_nxt    = r_par_en ? S_PARITY : S_STOP;
                  w_stop_cnt_nxt = 1'b0;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt    = S_STOP;
               w_cnt_nxt      = r_div - 16'd1;
               w_stop_cnt_nxt = 1'b0;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_stop2 && !r_stop_cnt) begin
                  w_stop_cnt_nxt = 1'b1;
                  w_cnt_nxt      = r_div - 16'd1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = 16'd0;
                  w_idx_nxt   = 3'd0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
         end
      endcase
   end

   always_comb begin
      w_tx = 1'b1;
      case (r_state)
         S_START:  w_tx = 1'b0;
         S_DATA:   w_tx = r_byte[r_idx];
         S_PARITY: w_tx = ^r_byte;
         default:  w_tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Directed bench for uart_tx_sb_ctrl: register access, frame shapes, busy gating and both resets.
`timescale 1ns/1ps
module tb_uart_tx_sb_ctrl;

   logic        clk;
   logic        resetn;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rdata;
   logic        tx;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_sb_ctrl #(.DEFAULT_DIV(87), .MIN_DIV(16)) dut (
      .clk_i          (clk),
      .resetn_i       (resetn),
      .req_i          (req),
      .write_enable_i (we),
      .addr_i         (addr),
      .write_data_i   (wd),
      .read_data_o    (rdata),
      .tx_o           (tx),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns one negedge later with the write applied.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wd = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
      d = rdata;
   endtask

   // Entered at the negedge of frame cycle 0; bits[0] is the first bit on the wire.
   task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits, input int div);
      int busy_cnt;
      busy_cnt = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < div; c++) begin
            if (c == 0)       check($sformatf("%s_b%0d_first", tag, b), {31'd0, tx}, {31'd0, bits[b]});
            if (c == div - 1) check($sformatf("%s_b%0d_last", tag, b), {31'd0, tx}, {31'd0, bits[b]});
            if (busy) busy_cnt++;
            @(negedge clk);
         end
      end
      check({tag, "_busy_len"}, busy_cnt, nbits * div);
      check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      check({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
   endtask

   logic [31:0] rd;
   int          cnt;

   initial begin
      req = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0; resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      bus_read(32'h08, rd); check("rst_div", rd, 32'd87);
      bus_read(32'h0C, rd); check("rst_par", rd, 32'd0);
      bus_read(32'h10, rd); check("rst_stop2", rd, 32'd0);
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // 0xA5, 8N1 at div 87
      bus_write(32'h00, 32'h0000_00A5);
      check_frame("a5", 12'b00_1101001010, 10, 87);
      bus_read(32'h04, rd); check("a5_busy_rd", rd, 32'd0);
      bus_read(32'h00, rd); check("a5_data_rd", rd, 32'hA5);

      // 0x07, even parity, 2 stop bits, div 16
      bus_write(32'h0C, 32'd1);
      bus_write(32'h10, 32'd1);
      bus_write(32'h08, 32'd16);
      bus_write(32'h00, 32'h07);
      check_frame("p07", 12'b111000001110, 12, 16);

      // New frame in the very cycle busy fell; mid-frame writes are dropped
      bus_write(32'h00, 32'h22);
      bus_write(32'h00, 32'h11);
      bus_write(32'h08, 32'd40);
      bus_read(32'h04, rd); check("mid_busy_rd", rd, 32'd1);
      bus_read(32'h08, rd); check("mid_div_rd", rd, 32'd16);
      cnt = 4;
      while (busy && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      check("mid_frame_len", cnt, 192);
      bus_read(32'h00, rd); check("mid_data_rd", rd, 32'h22);
      bus_read(32'h04, rd); check("post_busy_rd", rd, 32'd0);

      // DIV clamp, truncation and unmapped/write-only offsets
      bus_write(32'h08, 32'd5);
      bus_read(32'h08, rd); check("div_clamp", rd, 32'd16);
      bus_write(32'h08, 32'h0001_2345);
      bus_read(32'h08, rd); check("div_trunc", rd, 32'h2345);
      bus_read(32'h40, rd); check("unmapped_rd", rd, 32'd0);
      bus_read(32'h24, rd); check("srst_rd", rd, 32'd0);
      bus_write(32'h04, 32'd1);
      check("ro_write_busy", {31'd0, busy}, 32'd0);

      // Soft reset at data bit 4
      bus_write(32'h08, 32'd16);
      bus_write(32'h00, 32'hFF);
      repeat (88) @(negedge clk);
      check("srst_pre_busy", {31'd0, busy}, 32'd1);
      bus_write(32'h24, 32'd1);
      check("srst_busy", {31'd0, busy}, 32'd0);
      check("srst_tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      check("srst_busy_hold", {31'd0, busy}, 32'd0);
      bus_read(32'h08, rd); check("srst_div", rd, 32'd87);
      bus_read(32'h0C, rd); check("srst_par", rd, 32'd0);
      bus_read(32'h10, rd); check("srst_stop2", rd, 32'd0);
      bus_read(32'h00, rd); check("srst_data", rd, 32'd0);

      // Hardware reset at data bit 4, observed before any clock edge
      bus_write(32'h00, 32'hFF);
      repeat (5 * 87 + 40) @(negedge clk);
      check("hrst_pre_busy", {31'd0, busy}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("hrst_busy", {31'd0, busy}, 32'd0);
      check("hrst_tx", {31'd0, tx}, 32'd1);
      check("hrst_rdata", rdata, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      bus_read(32'h08, rd); check("hrst_div", rd, 32'd87);
      check("hrst_idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
